// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared types and helpers for the pipelined adder/subtractor
package pipe_addsub_pkg;

   typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_t;

   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Single full-adder cell: returns {carry_out, sum}
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational W-bit ripple adder slice built from full-adder cells
module add_slice
   import pipe_addsub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb_in
);

   logic       carry;
   logic [1:0] fa_r;

   always_comb begin
      carry    = ci;
      c_msb_in = ci;
      fa_r     = '0;
      s        = '0;
      for (int i = 0; i < W; i++) begin
         c_msb_in = carry;
         fa_r     = full_add(a[i], b[i], carry);
         s[i]     = fa_r[0];
         carry    = fa_r[1];
      end
      co = carry;
   end

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined ripple-carry adder/subtractor with valid/ready handshake
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  op_t              op,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SLICE = slice_w(WIDTH, STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
   end

   logic adv;
   assign adv    = !out_vld || out_rdy;
   assign in_rdy = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits not yet added when this stage captures, including its own slice
      localparam int REM = WIDTH - k * SLICE;

      logic [REM-1:0]         op_a, op_b;
      logic                   ci, vin;
      logic [SLICE-1:0]       sl_s;
      logic                   sl_co, sl_cm;
      logic [(k+1)*SLICE-1:0] sum_d, sum_q;
      logic                   c_q, vld_q;

      if (k == 0) begin : g_in
         assign op_a  = a;
         assign op_b  = (op == SUB) ? ~b : b;
         assign ci    = (op == SUB) ? 1'b1 : cin;
         assign vin   = in_vld && in_rdy;
         assign sum_d = sl_s;
      end else begin : g_mid
         assign op_a  = g_st[k-1].g_rem.rem_a_q;
         assign op_b  = g_st[k-1].g_rem.rem_b_q;
         assign ci    = g_st[k-1].c_q;
         assign vin   = g_st[k-1].vld_q;
         assign sum_d = {sl_s, g_st[k-1].sum_q};
      end

      add_slice #(.W(SLICE)) u_slice (
         .a        (op_a[SLICE-1:0]),
         .b        (op_b[SLICE-1:0]),
         .ci       (ci),
         .s        (sl_s),
         .co       (sl_co),
         .c_msb_in (sl_cm)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (adv) begin
            vld_q <= vin;
            c_q   <= sl_co;
            sum_q <= sum_d;
         end
      end

      if (k < STAGES - 1) begin : g_rem
         logic [REM-SLICE-1:0] rem_a_q, rem_b_q;
         logic                 unused_cm;
         assign unused_cm = sl_cm;

         always_ff @(posedge clk) begin
            if (adv) begin
               rem_a_q <= op_a[REM-1:SLICE];
               rem_b_q <= op_b[REM-1:SLICE];
            end
         end
      end else begin : g_out
         logic ovf_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= sl_co ^ sl_cm;
            end
         end
      end
   end

   assign out_vld = g_st[STAGES-1].vld_q;
   assign s       = g_st[STAGES-1].sum_q;
   assign cout    = g_st[STAGES-1].c_q;
   assign ovf     = g_st[STAGES-1].g_out.ovf_q;
   assign zero    = out_vld && (s == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard bench for pipe_addsub across three width/depth configurations
module tb_pipe_addsub;
   import pipe_addsub_pkg::*;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } res_t;

   typedef struct {
      res_t r;
      int   t_acc;
      bit   seen;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_vld;
   logic        cin;
   logic        out_rdy;
   op_t         op;
   logic [31:0] a_in, b_in;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic c, input op_t o, input int w);
      longint unsigned m  = (64'd1 << w) - 1;
      longint unsigned xa = {32'd0, x} & m;
      longint unsigned ya = {32'd0, y} & m;
      longint unsigned full;
      logic sa, sb, ss;
      res_t r;
      if (o == ADD) full = xa + ya + {63'd0, c};
      else          full = xa - ya;
      r.s  = 32'(full & m);
      r.co = (o == ADD) ? ((full >> w) != 0) : (xa >= ya);
      sa   = xa[w-1];
      sb   = ya[w-1];
      ss   = r.s[w-1];
      r.ov = (o == ADD) ? (sa == sb && ss != sa) : (sa != sb && ss != sa);
      r.z  = (r.s == 0);
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 1) ? 32 : 16;
      localparam int S = (g == 0) ? 4 : (g == 1) ? 8 : 1;

      logic         in_rdy_w, out_vld_w, cout_w, ovf_w, zero_w;
      logic [W-1:0] s_w;
      res_t         got;
      res_t         held;
      bit           held_v = 0;
      int           stall_last = -1;
      exp_t         q[$];

      pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .in_vld  (in_vld),
         .in_rdy  (in_rdy_w),
         .a       (a_in[W-1:0]),
         .b       (b_in[W-1:0]),
         .cin     (cin),
         .op      (op),
         .out_vld (out_vld_w),
         .out_rdy (out_rdy),
         .s       (s_w),
         .cout    (cout_w),
         .ovf     (ovf_w),
         .zero    (zero_w)
      );

      assign got = {32'(s_w), cout_w, ovf_w, zero_w};

      always @(negedge rst_n) begin
         #1;
         q.delete();
         held_v = 0;
         chk($sformatf("d%0d_reset_outputs", g), {31'd0, out_vld_w, got}, 64'd0);
         chk($sformatf("d%0d_reset_in_rdy", g), {63'd0, in_rdy_w}, 64'd1);
      end

      always @(negedge clk) begin
         if (rst_n === 1'b1) begin
            chk($sformatf("d%0d_in_rdy", g), {63'd0, in_rdy_w}, {63'd0, !out_vld_w || out_rdy});
            if (held_v)
               chk($sformatf("d%0d_stall_hold", g), {31'd0, out_vld_w, got}, {31'd0, 1'b1, held});
            if (out_vld_w) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL d%0d_spurious_output actual=%0h required=no_output", g, got);
               end else begin
                  if (!q[0].seen) begin
                     q[0].seen = 1;
                     if (stall_last < q[0].t_acc)
                        chk($sformatf("d%0d_latency", g), 64'(cyc - q[0].t_acc), 64'(S));
                  end
                  if (out_rdy) begin
                     chk($sformatf("d%0d_result", g), {29'd0, got}, {29'd0, q[0].r});
                     void'(q.pop_front());
                  end
               end
            end
            held_v = out_vld_w && !out_rdy;
            held   = got;
            if (held_v) stall_last = cyc;
            if (in_vld && in_rdy_w)
               q.push_back('{model(a_in, b_in, cin, op, W), cyc, 1'b0});
         end
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_8000;
         3:       return 32'h0000_7FFF;
         4:       return 32'h8000_0000;
         5:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic beat(input logic [31:0] x, input logic [31:0] y, input logic c, input op_t o);
      @(posedge clk);
      #1;
      in_vld = 1'b1;
      a_in   = x;
      b_in   = y;
      cin    = c;
      op     = o;
   endtask

   task automatic rand_beat();
      beat(pick(), pick(), 1'($urandom_range(0, 1)), op_t'($urandom_range(0, 1)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_vld = 1'b0;
      end
   endtask

   function automatic int pending();
      return g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size();
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int hold;
      rst_n   = 1'b1;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      a_in    = '0;
      b_in    = '0;
      cin     = 1'b0;
      op      = ADD;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, ADD);
      beat(32'h0000_8000, 32'h0000_0001, 1'b0, SUB);
      beat(32'h0000_0003, 32'h0000_0005, 1'b0, SUB);
      beat(32'h0000_7FFF, 32'h0000_0001, 1'b1, ADD);
      beat(32'h0000_0005, 32'h0000_0005, 1'b1, SUB);
      beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD);
      beat(32'h8000_0000, 32'h0000_0001, 1'b0, SUB);
      beat(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, ADD);
      idle(12);

      repeat (8) rand_beat();
      idle(12);

      hold = -1;
      for (int i = 0; i < 24; i++) begin
         rand_beat();
         if (hold < 0 && g_dut[0].out_vld_w) hold = 6;
         if (hold > 0) begin
            out_rdy = 1'b0;
            hold--;
         end else begin
            out_rdy = 1'b1;
         end
      end
      out_rdy = 1'b1;
      idle(12);

      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         a_in    = pick();
         b_in    = pick();
         cin     = 1'($urandom_range(0, 1));
         op      = op_t'($urandom_range(0, 1));
      end
      out_rdy = 1'b1;
      idle(12);

      repeat (3) rand_beat();
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(10);
      rand_beat();
      idle(12);

      for (int i = 0; i < 200 && pending() != 0; i++) @(posedge clk);
      chk("d0_drain", 64'(g_dut[0].q.size()), 64'd0);
      chk("d1_drain", 64'(g_dut[1].q.size()), 64'd0);
      chk("d2_drain", 64'(g_dut[2].q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
